// File: rtl/lock_access_sequencer_pkg.sv
// lock_access_sequencer_pkg
// Shared definitions for the lock access sequencer: FSM state encodings,
// code and failure-counter widths, and a small constant helper.
package lock_access_sequencer_pkg;

  localparam int unsigned CODE_WIDTH = 8;
  localparam int unsigned FAIL_W     = 2;
  localparam int unsigned STATE_W    = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_LOCKED = 3'd0,
    ST_ENTRY  = 3'd1,
    ST_CHECK  = 3'd2,
    ST_OPEN   = 3'd3,
    ST_ALARM  = 3'd4
  } state_e;

  // Larger of two elaboration-time values, used to size the shared timer
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lock_access_sequencer_timer.sv
// lock_cycle_timer
// Synchronous up-counter with clear, enable and a terminal-count flag.
// Ports:
//   clk      - clock, rising edge
//   i_clear  - synchronous clear (highest priority)
//   i_en     - count enable
//   i_limit  - terminal-count compare value
//   o_tc_c   - combinational: count == i_limit
module lock_cycle_timer #(
  parameter int unsigned WIDTH = 5
) (
  input  logic             clk,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_limit,
  output logic             o_tc_c
);

  logic [WIDTH-1:0] r_count;

  // Counter register
  always_ff @(posedge clk) begin
    if (i_clear) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_tc_c = (r_count == i_limit);

endmodule

// File: rtl/lock_access_sequencer.sv
// lock_access_sequencer
// Sequences access to the digital lock: opens a timed entry window when any
// code switch is set, latches the code on enter, compares it with the stored
// code, counts consecutive failures and escalates to a timed alarm/lockout.
// Optional build macro LOCK_ALARM_LATCH_EN: ALARM never expires (left only
// via clear), the timer is frozen in ALARM and LOCKOUT_CYC is unused.
// Ports:
//   clk          - clock, rising edge
//   clear        - synchronous active-high reset
//   sw[7:0]      - code switches
//   enter        - code enter level, sampled in ENTRY
//   relock       - OPEN -> LOCKED
//   code_load    - in OPEN, store sw as new code
//   locked       - lock engaged
//   alarm        - alarm active
//   timeout      - one-cycle pulse on entry-window expiry
//   unlock_pulse - one-cycle pulse on a successful match
//   fail_cnt     - consecutive failure count (saturates at 3)
//   curr_state   - FSM state encoding
module lock_access_sequencer
  import lock_access_sequencer_pkg::*;
#(
  parameter logic [CODE_WIDTH-1:0] CODE_RESET  = 8'hF0,
  parameter int unsigned           TIMEOUT_CYC = 16,
  parameter int unsigned           MAX_FAILS   = 3,
  parameter int unsigned           LOCKOUT_CYC = 32
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic [CODE_WIDTH-1:0] sw,
  input  logic                  enter,
  input  logic                  relock,
  input  logic                  code_load,
  output logic                  locked,
  output logic                  alarm,
  output logic                  timeout,
  output logic                  unlock_pulse,
  output logic [FAIL_W-1:0]     fail_cnt,
  output logic [STATE_W-1:0]    curr_state
);

  localparam int unsigned TMR_W = $clog2(max_u(TIMEOUT_CYC, LOCKOUT_CYC));

  state_e                r_state,      w_state_nxt;
  logic [CODE_WIDTH-1:0] r_code,       w_code_nxt;
  logic [CODE_WIDTH-1:0] r_entry,      w_entry_nxt;
  logic [FAIL_W-1:0]     r_fail_cnt,   w_fail_nxt;
  logic                  r_locked,     w_locked_nxt;
  logic                  r_alarm,      w_alarm_nxt;
  logic                  r_timeout,    w_timeout_nxt;
  logic                  r_unlock,     w_unlock_nxt;

  logic [FAIL_W-1:0]     w_fail_inc;
  logic                  w_fail_trip;
  logic                  w_tmr_en;
  logic                  w_tmr_clr;
  logic [TMR_W-1:0]      w_tmr_limit;
  logic                  w_tmr_tc;

  // Saturating failure increment and alarm threshold
  assign w_fail_inc  = (r_fail_cnt == FAIL_W'(3)) ? r_fail_cnt : r_fail_cnt + FAIL_W'(1);
  assign w_fail_trip = (w_fail_inc == FAIL_W'(MAX_FAILS));

  // One timer shared by the entry window and the alarm lockout
  lock_cycle_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .clk     (clk),
    .i_clear (w_tmr_clr),
    .i_en    (w_tmr_en),
    .i_limit (w_tmr_limit),
    .o_tc_c  (w_tmr_tc)
  );

  // State and output registers
  always_ff @(posedge clk) begin
    if (clear) begin
      r_state    <= ST_LOCKED;
      r_code     <= CODE_RESET;
      r_entry    <= '0;
      r_fail_cnt <= '0;
      r_locked   <= 1'b1;
      r_alarm    <= 1'b0;
      r_timeout  <= 1'b0;
      r_unlock   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_code     <= w_code_nxt;
      r_entry    <= w_entry_nxt;
      r_fail_cnt <= w_fail_nxt;
      r_locked   <= w_locked_nxt;
      r_alarm    <= w_alarm_nxt;
      r_timeout  <= w_timeout_nxt;
      r_unlock   <= w_unlock_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt   = r_state;
    w_code_nxt    = r_code;
    w_entry_nxt   = r_entry;
    w_fail_nxt    = r_fail_cnt;
    w_timeout_nxt = 1'b0;
    w_unlock_nxt  = 1'b0;
    w_tmr_en      = 1'b0;
    w_tmr_limit   = TMR_W'(TIMEOUT_CYC - 1);

    case (r_state)
      ST_LOCKED: begin
        if (sw != '0) w_state_nxt = ST_ENTRY;
      end
      ST_ENTRY: begin
        w_tmr_en = 1'b1;
        // enter beats a coincident expiry
        if (enter) begin
          w_entry_nxt = sw;
          w_state_nxt = ST_CHECK;
        end else if (w_tmr_tc) begin
          w_timeout_nxt = 1'b1;
          w_fail_nxt    = w_fail_inc;
          w_state_nxt   = w_fail_trip ? ST_ALARM : ST_LOCKED;
        end
      end
      ST_CHECK: begin
        if (r_entry == r_code) begin
          w_state_nxt  = ST_OPEN;
          w_unlock_nxt = 1'b1;
          w_fail_nxt   = '0;
        end else begin
          w_fail_nxt  = w_fail_inc;
          w_state_nxt = w_fail_trip ? ST_ALARM : ST_LOCKED;
        end
      end
      ST_OPEN: begin
        // a load coincident with relock still lands
        if (code_load) w_code_nxt  = sw;
        if (relock)    w_state_nxt = ST_LOCKED;
      end
      ST_ALARM: begin
`ifdef LOCK_ALARM_LATCH_EN
        w_tmr_en = 1'b0;
`else
        w_tmr_en    = 1'b1;
        w_tmr_limit = TMR_W'(LOCKOUT_CYC - 1);
        if (w_tmr_tc) begin
          w_state_nxt = ST_LOCKED;
          w_fail_nxt  = '0;
        end
`endif
      end
      default: begin
        w_state_nxt = ST_LOCKED;
      end
    endcase

    w_locked_nxt = (w_state_nxt != ST_OPEN);
    w_alarm_nxt  = (w_state_nxt == ST_ALARM);
    // Timer restarts on every state change
    w_tmr_clr    = clear || (w_state_nxt != r_state);
  end

  assign locked       = r_locked;
  assign alarm        = r_alarm;
  assign timeout      = r_timeout;
  assign unlock_pulse = r_unlock;
  assign fail_cnt     = r_fail_cnt;
  assign curr_state   = r_state;

endmodule

// File: tb/tb_lock_access_sequencer.sv
// Directed self-checking bench for lock_access_sequencer.
module tb_lock_access_sequencer;

  logic       clk = 1'b0;
  logic       clear;
  logic [7:0] sw;
  logic       enter;
  logic       relock;
  logic       code_load;
  logic       locked;
  logic       alarm;
  logic       timeout;
  logic       unlock_pulse;
  logic [1:0] fail_cnt;
  logic [2:0] curr_state;

  int n_tests = 0;
  int n_fails = 0;

  lock_access_sequencer dut (
    .clk          (clk),
    .clear        (clear),
    .sw           (sw),
    .enter        (enter),
    .relock       (relock),
    .code_load    (code_load),
    .locked       (locked),
    .alarm        (alarm),
    .timeout      (timeout),
    .unlock_pulse (unlock_pulse),
    .fail_cnt     (fail_cnt),
    .curr_state   (curr_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // state, locked, alarm, fail_cnt in one go
  task automatic chk_st(input string tag, input logic [2:0] st, input logic lk,
                        input logic al, input logic [1:0] fc);
    chk({tag, ".state"},  8'(curr_state), 8'(st));
    chk({tag, ".locked"}, 8'(locked),     8'(lk));
    chk({tag, ".alarm"},  8'(alarm),      8'(al));
    chk({tag, ".fail"},   8'(fail_cnt),   8'(fc));
  endtask

  // Present a code, enter it the next cycle, leave the result visible
  task automatic try_code(input logic [7:0] code);
    sw = code;
    tick();            // LOCKED -> ENTRY
    enter = 1'b1;
    tick();            // ENTRY -> CHECK
    enter = 1'b0;
    sw = 8'h00;
    tick();            // CHECK -> result
  endtask

  initial begin
    clear = 1'b1; sw = 8'h00; enter = 1'b0; relock = 1'b0; code_load = 1'b0;
    tick();
    clear = 1'b0;

    // Reset state and idle
    chk_st("reset", 3'd0, 1'b1, 1'b0, 2'd0);
    chk("reset.timeout", 8'(timeout), 8'h0);
    chk("reset.unlock", 8'(unlock_pulse), 8'h0);
    for (int i = 0; i < 50; i++) begin
      tick();
      chk_st("idle", 3'd0, 1'b1, 1'b0, 2'd0);
    end

    // Correct code, two-cycle gap before enter
    sw = 8'hF0;
    tick();
    chk_st("ok.entry", 3'd1, 1'b1, 1'b0, 2'd0);
    tick();
    enter = 1'b1;
    tick();
    enter = 1'b0; sw = 8'h00;
    chk_st("ok.check", 3'd2, 1'b1, 1'b0, 2'd0);
    tick();
    chk_st("ok.open", 3'd3, 1'b0, 1'b0, 2'd0);
    chk("ok.unlock", 8'(unlock_pulse), 8'h1);
    tick();
    chk("ok.unlock_end", 8'(unlock_pulse), 8'h0);
    chk_st("ok.hold", 3'd3, 1'b0, 1'b0, 2'd0);
    relock = 1'b1;
    tick();
    relock = 1'b0;
    chk_st("ok.relock", 3'd0, 1'b1, 1'b0, 2'd0);

    // Three wrong codes escalate to alarm
    try_code(8'h0F);
    chk_st("bad1", 3'd0, 1'b1, 1'b0, 2'd1);
    try_code(8'h0F);
    chk_st("bad2", 3'd0, 1'b1, 1'b0, 2'd2);
    try_code(8'h0F);
    chk_st("bad3", 3'd4, 1'b1, 1'b1, 2'd3);
    sw = 8'hF0; enter = 1'b1;   // ignored in ALARM
`ifdef LOCK_ALARM_LATCH_EN
    for (int i = 0; i < 40; i++) tick();
    chk_st("alarm.latched", 3'd4, 1'b1, 1'b1, 2'd3);
    sw = 8'h00; enter = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_st("alarm.clear", 3'd0, 1'b1, 1'b0, 2'd0);
`else
    for (int i = 0; i < 31; i++) tick();
    chk_st("alarm.hold", 3'd4, 1'b1, 1'b1, 2'd3);
    sw = 8'h00; enter = 1'b0;
    tick();
    chk_st("alarm.expire", 3'd0, 1'b1, 1'b0, 2'd0);
`endif

    // Entry window timeout
    sw = 8'h01;
    tick();
    sw = 8'h00;
    for (int i = 0; i < 15; i++) tick();
    chk_st("to.pre", 3'd1, 1'b1, 1'b0, 2'd0);
    chk("to.pre_pulse", 8'(timeout), 8'h0);
    tick();
    chk_st("to.fire", 3'd0, 1'b1, 1'b0, 2'd1);
    chk("to.pulse", 8'(timeout), 8'h1);
    tick();
    chk("to.pulse_end", 8'(timeout), 8'h0);

    // enter on the expiry cycle wins
    sw = 8'h01;
    tick();
    sw = 8'h00;
    for (int i = 0; i < 15; i++) tick();
    sw = 8'hF0; enter = 1'b1;
    tick();
    sw = 8'h00; enter = 1'b0;
    chk_st("race.check", 3'd2, 1'b1, 1'b0, 2'd1);
    chk("race.no_timeout", 8'(timeout), 8'h0);
    tick();
    chk_st("race.open", 3'd3, 1'b0, 1'b0, 2'd0);
    chk("race.unlock", 8'(unlock_pulse), 8'h1);

    // Code change: load alone, then load with relock
    sw = 8'h5A; code_load = 1'b1;
    tick();
    chk_st("load.stay", 3'd3, 1'b0, 1'b0, 2'd0);
    sw = 8'hA5; relock = 1'b1;
    tick();
    sw = 8'h00; code_load = 1'b0; relock = 1'b0;
    chk_st("load.relock", 3'd0, 1'b1, 1'b0, 2'd0);
    try_code(8'hA5);
    chk_st("new.open", 3'd3, 1'b0, 1'b0, 2'd0);
    chk("new.unlock", 8'(unlock_pulse), 8'h1);
    relock = 1'b1;
    tick();
    relock = 1'b0;
    try_code(8'h5A);
    chk_st("partial.bad", 3'd0, 1'b1, 1'b0, 2'd1);
    try_code(8'hF0);
    chk_st("old.bad", 3'd0, 1'b1, 1'b0, 2'd2);

    // code_load ignored outside OPEN
    code_load = 1'b1;
    tick();
    code_load = 1'b0;
    try_code(8'hA5);
    chk_st("ignload.open", 3'd3, 1'b0, 1'b0, 2'd0);
    relock = 1'b1;
    tick();
    relock = 1'b0;

    // Reset mid-ENTRY at timer 7
    try_code(8'h11);
    chk_st("mid.fail", 3'd0, 1'b1, 1'b0, 2'd1);
    sw = 8'h01;
    tick();
    sw = 8'h00;
    for (int i = 0; i < 7; i++) tick();
    chk_st("mid.entry", 3'd1, 1'b1, 1'b0, 2'd1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_st("mid.clear", 3'd0, 1'b1, 1'b0, 2'd0);
    // full window after reset proves the timer restarted
    sw = 8'h01;
    tick();
    sw = 8'h00;
    for (int i = 0; i < 15; i++) tick();
    chk("mid.window", 8'(timeout), 8'h0);
    tick();
    chk("mid.timeout", 8'(timeout), 8'h1);
    // stored code back to reset value
    try_code(8'hF0);
    chk_st("mid.code_reset", 3'd3, 1'b0, 1'b0, 2'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
    $finish;
  end

endmodule
